// File: rtl/add_arb_pkg.sv
// Shared constants and helpers for the float-adder arbiter.
// The tag and FIFO-entry structs depend on N_REQ, so they are declared in the top.
package add_arb_pkg;

  localparam int WORD_W = 32;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

  // Increment modulo depth; supports non-power-of-two ranges.
  function automatic int wrap_inc(input int p, input int depth);
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/add_arb_rr.sv
// Round-robin grant: searches from the pointer, wraps, and skips idle requesters.
// The pointer moves to the slot after the last grant whenever an issue happens.
module add_arb_rr
  import add_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic                       en,
  input  logic                       update,
  output logic [N_REQ-1:0]           grant,
  output logic [id_width(N_REQ)-1:0] grant_id
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  always_comb begin
    int   idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update) ptr_d = ID_W'(wrap_inc(int'(grant_id), N_REQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/add_arbiter.sv
// Shares one fixed-latency pipelined float adder among N_REQ requesters and returns
// tagged results in issue order through a credit-protected output FIFO.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WORD_W-1:0]    req_a,
  input  logic [N_REQ*WORD_W-1:0]    req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [id_width(N_REQ)-1:0] rsp_id,
  output logic [WORD_W-1:0]          rsp_z,
  output logic [WORD_W-1:0]          add_a,
  output logic [WORD_W-1:0]          add_b,
  input  logic [WORD_W-1:0]          add_z
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [WORD_W-1:0] z;
  } entry_t;

  // Handshake: a transfer happens on a rising edge where req_valid[i] & req_ready[i]
  // (issue) or rsp_valid & rsp_ready (pop); valid must hold with stable data until then.

  logic              en_q, en_d;
  logic [WORD_W-1:0] add_a_q, add_a_d;
  logic [WORD_W-1:0] add_b_q, add_b_d;
  tag_t              tag_q [LATENCY+1];
  tag_t              tag_d [LATENCY+1];
  logic [CNT_W-1:0]  inflight_count_q, inflight_count_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];
  logic              rsp_valid_q, rsp_valid_d;
  entry_t            rsp_q, rsp_d;

  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic [ID_W-1:0]   grant_id;
  entry_t            push_entry;
  logic [CNT_W-1:0]  fifo_rem;

  // Every issued op holds a credit from grant until it leaves the FIFO.
  assign credit_ok = (int'(fifo_count_q) + int'(inflight_count_q)) < FIFO_DEPTH;
  assign issue     = |(req_valid & req_ready);

  add_arb_rr #(
    .N_REQ (N_REQ)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .en       (en_q & credit_ok),
    .update   (issue),
    .grant    (req_ready),
    .grant_id (grant_id)
  );

  always_comb begin
    en_d    = 1'b1;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (issue) begin
      add_a_d = req_a[WORD_W*int'(grant_id) +: WORD_W];
      add_b_d = req_b[WORD_W*int'(grant_id) +: WORD_W];
    end
  end

  // Stage 0 pairs with the add_a/add_b register; stage LATENCY lines up with add_z.
  always_comb begin
    tag_d[0].valid = issue;
    tag_d[0].id    = grant_id;
    for (int k = 1; k <= LATENCY; k++) tag_d[k] = tag_q[k-1];
  end

  assign push             = tag_q[LATENCY].valid;
  assign push_entry.id    = tag_q[LATENCY].id;
  assign push_entry.z     = add_z;
  assign pop              = rsp_valid_q & rsp_ready;
  assign fifo_rem         = fifo_count_q - CNT_W'(pop);

  always_comb begin
    inflight_count_d = inflight_count_q + CNT_W'(issue) - CNT_W'(push);
    fifo_count_d     = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d         = pop  ? PTR_W'(wrap_inc(int'(rd_ptr_q), FIFO_DEPTH)) : rd_ptr_q;
    wr_ptr_d         = push ? PTR_W'(wrap_inc(int'(wr_ptr_q), FIFO_DEPTH)) : wr_ptr_q;
    mem_d            = mem_q;
    if (push) mem_d[wr_ptr_q] = push_entry;
  end

  // The output register mirrors the head; a push into an empty FIFO bypasses storage.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    if (pop || !rsp_valid_q) begin
      if (fifo_rem != '0) begin
        rsp_valid_d = 1'b1;
        rsp_d       = mem_q[rd_ptr_d];
      end else if (push) begin
        rsp_valid_d = 1'b1;
        rsp_d       = push_entry;
      end else begin
        rsp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q             <= 1'b0;
      add_a_q          <= '0;
      add_b_q          <= '0;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
      inflight_count_q <= '0;
      fifo_count_q     <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_q            <= '0;
    end else begin
      en_q             <= en_d;
      add_a_q          <= add_a_d;
      add_b_q          <= add_b_d;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= tag_d[k];
      inflight_count_q <= inflight_count_d;
      fifo_count_q     <= fifo_count_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_q            <= rsp_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (int'(fifo_count_q) == FIFO_DEPTH) && !pop));

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_z     = rsp_q.z;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: bench-side pipelined adder, cycle-stepped stimulus
// with hand-derived grant sequences, and an in-order response scoreboard.
module tb_add_arbiter;

  localparam int N_REQ      = 4;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int EXP_W      = 34;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N_REQ-1:0]      req_valid = '0;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*32-1:0]   req_a = '0;
  logic [N_REQ*32-1:0]   req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic [31:0]           rsp_z;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [31:0]           add_z;

  int                    n_checks = 0;
  int                    n_fail = 0;
  logic [EXP_W-1:0]      exp_q[$];
  logic [EXP_W-1:0]      mon_e;
  int                    ak[N_REQ];
  int                    bk[N_REQ];
  int                    lat_n;
  int                    burst_w;
  int                    burst_cnt;
  logic [31:0]           held_z;
  logic [31:0]           pipe_q[LATENCY];

  add_arbiter #(
    .N_REQ      (N_REQ),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_z     (add_z)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] fl(input int n);
    case (n)
      1:  return 32'h3F800000;
      2:  return 32'h40000000;
      3:  return 32'h40400000;
      4:  return 32'h40800000;
      5:  return 32'h40A00000;
      6:  return 32'h40C00000;
      7:  return 32'h40E00000;
      8:  return 32'h41000000;
      9:  return 32'h41100000;
      10: return 32'h41200000;
      11: return 32'h41300000;
      12: return 32'h41400000;
      13: return 32'h41500000;
      14: return 32'h41600000;
      15: return 32'h41700000;
      16: return 32'h41800000;
      default: return 32'h0;
    endcase
  endfunction

  // Positive normal operands only, truncating alignment.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  e;
    logic [24:0] ma, mb, s;
    int          d;
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    ma = {2'b01, a[22:0]};
    mb = {2'b01, b[22:0]};
    if (a[30:23] >= b[30:23]) begin
      d  = int'(a[30:23]) - int'(b[30:23]);
      e  = a[30:23];
      mb = (d > 24) ? 25'h0 : (mb >> d);
    end else begin
      d  = int'(b[30:23]) - int'(a[30:23]);
      e  = b[30:23];
      ma = (d > 24) ? 25'h0 : (ma >> d);
    end
    s = ma + mb;
    if (s[24]) begin
      s = s >> 1;
      e = e + 8'd1;
    end
    return {1'b0, e, s[22:0]};
  endfunction

  // Bench-side adder: LATENCY register stages from add_a/add_b to add_z.
  always @(posedge clk) begin
    pipe_q[0] <= fadd(add_a, add_b);
    for (int k = 1; k < LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
  end
  assign add_z = pipe_q[LATENCY-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[32*i +: 32] = fl(ak[i]);
      req_b[32*i +: 32] = fl(bk[i]);
    end
  endtask

  // Entered #1 after a rising edge; leaves #1 after the next one.
  task automatic cycle(input logic [N_REQ-1:0] valid, input logic [N_REQ-1:0] exp_grant,
                       input string tag);
    int id;
    req_valid = valid;
    set_ops();
    #1;
    check(tag, req_ready, exp_grant);
    if (exp_grant != '0) begin
      id = 0;
      for (int i = 0; i < N_REQ; i++) if (exp_grant[i]) id = i;
      exp_q.push_back({2'(id), fl(ak[id] + bk[id])});
      ak[id] = (ak[id] >= 15) ? 1 : ak[id] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string pfx);
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check({pfx, "_req_ready"}, req_ready, 0);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_id"}, rsp_id, 0);
    check({pfx, "_rsp_z"}, rsp_z, 0);
    check({pfx, "_add_a"}, add_a, 0);
    check({pfx, "_add_b"}, add_b, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", rsp_id, mon_e[33:32]);
        check("rsp_z", rsp_z, mon_e[31:0]);
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      ak[i] = 1;
      bk[i] = 1;
    end
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Single request: 1.0 + 2.0 from requester 1.
    rsp_ready = 1'b1;
    ak[1] = 1;
    bk[1] = 2;
    cycle(4'b0010, 4'b0010, "t1_grant");
    req_valid = '0;
    lat_n = 0;
    while (!rsp_valid && lat_n < 20) begin
      @(posedge clk);
      #1;
      lat_n++;
    end
    check("t1_latency", lat_n, 5);
    check("t1_rsp_id", rsp_id, 1);
    check("t1_rsp_z", rsp_z, 32'h40400000);
    drain("t1_drain");
    bk[1] = 1;

    // All four streaming: strict rotation and back-to-back responses.
    do_reset("t2_rst");
    rsp_ready = 1'b1;
    burst_w   = 0;
    burst_cnt = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) cycle(4'b1111, 4'(1 << (i % 4)), "t2_grant");
        req_valid = '0;
      end
      begin
        while (!rsp_valid && burst_w < 40) begin
          @(negedge clk);
          burst_w++;
        end
        while (rsp_valid && burst_cnt < 40) begin
          @(negedge clk);
          burst_cnt++;
        end
      end
    join
    check("t2_burst", burst_cnt, 12);
    drain("t2_drain");

    // Requester 2 streaming into a stalled consumer, then credit-boundary resume.
    do_reset("t3_rst");
    rsp_ready = 1'b0;
    for (int i = 0; i < 14; i++) cycle(4'b0100, (i < 8) ? 4'b0100 : 4'b0000, "t3_grant");
    check("t3_full_valid", rsp_valid, 1);
    check("t3_full_id", rsp_id, 2);
    check("t3_full_z", rsp_z, exp_q[0][31:0]);
    held_z = exp_q[0][31:0];
    cycle(4'b0100, 4'b0000, "t3_hold_grant");
    check("t3_hold_z", rsp_z, held_z);
    rsp_ready = 1'b1;
    cycle(4'b0100, 4'b0000, "t3_pop_edge_grant");
    cycle(4'b0100, 4'b0100, "t3_resume_grant");
    for (int i = 0; i < 7; i++) cycle(4'b0100, 4'b0100, "t5_credit_grant");
    drain("t3_drain");

    // Solo requester 0, then 3 joins and grants alternate.
    do_reset("t4_rst");
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle(4'b0001, 4'b0001, "t4_solo_grant");
    for (int i = 0; i < 6; i++) cycle(4'b1001, (i % 2 == 0) ? 4'b1000 : 4'b0001, "t4_alt_grant");
    drain("t4_drain");

    // Reset with 3 ops in flight and 2 queued.
    do_reset("t6_rst0");
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle(4'b0010, 4'b0010, "t6_fill_grant");
    for (int i = 0; i < 2; i++) cycle(4'b0000, 4'b0000, "t6_idle_grant");
    check("t6_pre_valid", rsp_valid, 1);
    do_reset("t6_mid");
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0000, 4'b0000, "t6_quiet_grant");
      check("t6_quiet_valid", rsp_valid, 0);
    end
    cycle(4'b1010, 4'b0010, "t6_first_grant");
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
